// File: rtl/sha256_msg_padder.sv
// Byte-stream front end for the SHA-256 core: buffers message bytes, applies
// the 0x80 / zero / bit-length padding and emits 512-bit blocks with first/last flags.
module sha256_msg_padder #(
    parameter int LEN_W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic [0:511] blk_data,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic         blk_first,
    output logic         blk_last
);

    // state | meaning
    // FILL  | accepting message bytes into the buffer
    // PAD   | one cycle: place 0x80 and, if it fits, the bit length
    // PAD2  | one cycle: build the extra length-only block
    // OUT   | presenting a block, waiting for blk_ready
    typedef enum logic [1:0] {FILL, PAD, PAD2, OUT} state_t;

    state_t             state;
    logic [6:0]         idx;
    logic [LEN_W-4:0]   count;
    logic [0:511]       buffer;
    logic               first_pending;
    logic               pad2_pending;
    logic               pad_placed;
    logic [63:0]        len_field;
    logic [8:0]         byte_pos;

    always_comb begin
        len_field = '0;
        len_field[LEN_W-1:0] = {count, 3'b000};
    end

    assign byte_pos = {idx[5:0], 3'b000};
    assign in_ready = (state == FILL) && !reset;
    assign blk_data = buffer;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= FILL;
            idx           <= '0;
            count         <= '0;
            buffer        <= '0;
            first_pending <= 1'b1;
            pad2_pending  <= 1'b0;
            pad_placed    <= 1'b0;
            blk_valid     <= 1'b0;
            blk_first     <= 1'b0;
            blk_last      <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (in_valid) begin
                        buffer[byte_pos +: 8] <= in_data;
                        idx   <= idx + 7'd1;
                        count <= count + 1'b1;
                        if (in_last) begin
                            state <= PAD;
                        end else if (idx == 7'd63) begin
                            idx       <= '0;
                            state     <= OUT;
                            blk_valid <= 1'b1;
                            blk_first <= first_pending;
                            blk_last  <= 1'b0;
                        end
                    end
                end
                PAD: begin
                    // bytes past idx are already zero: the buffer is cleared on every block exit
                    state     <= OUT;
                    blk_valid <= 1'b1;
                    blk_first <= first_pending;
                    if (idx == 7'd64) begin
                        pad2_pending <= 1'b1;
                        pad_placed   <= 1'b0;
                        blk_last     <= 1'b0;
                    end else begin
                        buffer[byte_pos +: 8] <= 8'h80;
                        if (idx <= 7'd55) begin
                            buffer[448 +: 64] <= len_field;
                            blk_last          <= 1'b1;
                        end else begin
                            pad2_pending <= 1'b1;
                            pad_placed   <= 1'b1;
                            blk_last     <= 1'b0;
                        end
                    end
                end
                PAD2: begin
                    buffer       <= {(pad_placed ? 8'h00 : 8'h80), 440'h0, len_field};
                    pad2_pending <= 1'b0;
                    state        <= OUT;
                    blk_valid    <= 1'b1;
                    blk_first    <= first_pending;
                    blk_last     <= 1'b1;
                end
                OUT: begin
                    if (blk_ready) begin
                        blk_valid     <= 1'b0;
                        blk_first     <= 1'b0;
                        blk_last      <= 1'b0;
                        first_pending <= 1'b0;
                        if (blk_last) begin
                            count         <= '0;
                            first_pending <= 1'b1;
                        end
                        if (pad2_pending) begin
                            state <= PAD2;
                        end else begin
                            buffer <= '0;
                            idx    <= '0;
                            state  <= FILL;
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder: known messages against hand-built padded blocks.
module tb_sha256_msg_padder;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [7:0]   in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic         in_ready;
    logic [0:511] blk_data;
    logic         blk_valid;
    logic         blk_ready = 1'b0;
    logic         blk_first;
    logic         blk_last;

    int total = 0;
    int bad = 0;

    logic [7:0]   msg [0:127];
    int           msg_len;
    logic [0:511] got_a, got_b, exp_a, exp_b, exp_abc;
    logic         fa, la, fb, lb;

    sha256_msg_padder #(.LEN_W(64)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .blk_data(blk_data), .blk_valid(blk_valid), .blk_ready(blk_ready),
        .blk_first(blk_first), .blk_last(blk_last)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog simulation did not finish, required finish");
        $fatal(1);
    end

    task automatic load_str(input string s);
        msg_len = s.len();
        for (int i = 0; i < msg_len; i++) msg[i] = s[i];
    endtask

    task automatic load_fill(input int n, input logic [7:0] v, input bit incr);
        msg_len = n;
        for (int i = 0; i < n; i++) msg[i] = incr ? 8'(i) : v;
    endtask

    // entered at a negedge; returns at the negedge after the final byte handshake
    task automatic send_msg(input bit with_last);
        for (int i = 0; i < msg_len; i++) begin
            int t;
            t = 0;
            in_data  = msg[i];
            in_valid = 1'b1;
            in_last  = with_last && (i == msg_len - 1);
            while (!in_ready && t < 500) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) begin
                total++;
                bad++;
                $display("FAIL send_timeout byte=%0d in_ready=0 required 1", i);
                in_valid = 1'b0;
                in_last  = 1'b0;
                return;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic recv_block(output logic [0:511] d, output logic f, output logic l);
        int t;
        t = 0;
        while (!blk_valid && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!blk_valid) begin
            total++;
            bad++;
            $display("FAIL recv_timeout blk_valid=0 required 1");
            d = '0; f = 1'b0; l = 1'b0;
            return;
        end
        d = blk_data; f = blk_first; l = blk_last;
        blk_ready = 1'b1;
        @(negedge clk);
        blk_ready = 1'b0;
    endtask

    task automatic run_one();
        fork
            send_msg(1'b1);
            recv_block(got_a, fa, la);
        join
    endtask

    task automatic run_two();
        fork
            send_msg(1'b1);
            begin
                recv_block(got_a, fa, la);
                recv_block(got_b, fb, lb);
            end
        join
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        total++; if (blk_valid !== 1'b0) begin bad++; $display("FAIL rst_blk_valid got=%b exp=0", blk_valid); end
        total++; if (blk_first !== 1'b0 || blk_last !== 1'b0) begin bad++; $display("FAIL rst_flags got=%b%b exp=00", blk_first, blk_last); end
        total++; if (blk_data !== 512'h0) begin bad++; $display("FAIL rst_blk_data got=%h exp=0", blk_data); end
        reset = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_in_ready got=%b exp=1", in_ready); end
        @(negedge clk);
    endtask

    task automatic test_abc();
        load_str("abc");
        send_msg(1'b1);
        total++; if (blk_valid !== 1'b0) begin bad++; $display("FAIL abc_latency_early blk_valid got=%b exp=0", blk_valid); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL abc_pad_in_ready got=%b exp=0", in_ready); end
        @(negedge clk);
        total++; if (blk_valid !== 1'b1) begin bad++; $display("FAIL abc_latency blk_valid got=%b exp=1", blk_valid); end
        recv_block(got_a, fa, la);
        total++; if (got_a !== exp_abc) begin bad++; $display("FAIL abc_data got=%h exp=%h", got_a, exp_abc); end
        total++; if (fa !== 1'b1 || la !== 1'b1) begin bad++; $display("FAIL abc_flags got=%b%b exp=11", fa, la); end
    endtask

    task automatic test_fpga();
        load_str("projectfpga.com");
        exp_a = {"projectfpga.com", 8'h80, 320'h0, 64'h78};
        run_one();
        total++; if (got_a !== exp_a) begin bad++; $display("FAIL fpga_data got=%h exp=%h", got_a, exp_a); end
        total++; if (fa !== 1'b1 || la !== 1'b1) begin bad++; $display("FAIL fpga_flags got=%b%b exp=11", fa, la); end
    endtask

    task automatic test_55();
        load_fill(55, 8'h61, 1'b0);
        exp_a = {{55{8'h61}}, 8'h80, 64'h1B8};
        run_one();
        total++; if (got_a !== exp_a) begin bad++; $display("FAIL len55_data got=%h exp=%h", got_a, exp_a); end
        total++; if (fa !== 1'b1 || la !== 1'b1) begin bad++; $display("FAIL len55_flags got=%b%b exp=11", fa, la); end
    endtask

    task automatic test_56();
        load_fill(56, 8'h61, 1'b0);
        exp_a = {{56{8'h61}}, 8'h80, 56'h0};
        exp_b = {448'h0, 64'h1C0};
        run_two();
        total++; if (got_a !== exp_a) begin bad++; $display("FAIL len56_a_data got=%h exp=%h", got_a, exp_a); end
        total++; if (fa !== 1'b1 || la !== 1'b0) begin bad++; $display("FAIL len56_a_flags got=%b%b exp=10", fa, la); end
        total++; if (got_b !== exp_b) begin bad++; $display("FAIL len56_b_data got=%h exp=%h", got_b, exp_b); end
        total++; if (fb !== 1'b0 || lb !== 1'b1) begin bad++; $display("FAIL len56_b_flags got=%b%b exp=01", fb, lb); end
    endtask

    task automatic test_64_65(input int n);
        load_fill(n, 8'h00, 1'b1);
        for (int i = 0; i < 64; i++) exp_a[8*i +: 8] = 8'(i);
        if (n == 64) exp_b = {8'h80, 440'h0, 64'h200};
        else         exp_b = {8'h40, 8'h80, 432'h0, 64'h208};
        run_two();
        total++; if (got_a !== exp_a) begin bad++; $display("FAIL len%0d_a_data got=%h exp=%h", n, got_a, exp_a); end
        total++; if (fa !== 1'b1 || la !== 1'b0) begin bad++; $display("FAIL len%0d_a_flags got=%b%b exp=10", n, fa, la); end
        total++; if (got_b !== exp_b) begin bad++; $display("FAIL len%0d_b_data got=%h exp=%h", n, got_b, exp_b); end
        total++; if (fb !== 1'b0 || lb !== 1'b1) begin bad++; $display("FAIL len%0d_b_flags got=%b%b exp=01", n, fb, lb); end
    endtask

    task automatic test_backpressure();
        int t;
        load_str("abc");
        send_msg(1'b1);
        t = 0;
        while (!blk_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        in_data  = 8'h55;
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            total++; if (blk_valid !== 1'b1) begin bad++; $display("FAIL bp_valid cycle=%0d got=%b exp=1", c, blk_valid); end
            total++; if (blk_data !== exp_abc) begin bad++; $display("FAIL bp_data cycle=%0d got=%h exp=%h", c, blk_data, exp_abc); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cycle=%0d got=%b exp=0", c, in_ready); end
            @(negedge clk);
        end
        in_valid = 1'b0;
        blk_ready = 1'b1;
        @(negedge clk);
        blk_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            total++; if (blk_valid !== 1'b0) begin bad++; $display("FAIL bp_extra_block cycle=%0d got=%b exp=0", c, blk_valid); end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        load_str("abc");
        send_msg(1'b1);
        recv_block(got_a, fa, la);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready got=%b exp=1", in_ready); end
        send_msg(1'b1);
        recv_block(got_b, fb, lb);
        total++; if (got_a !== exp_abc) begin bad++; $display("FAIL b2b_first_data got=%h exp=%h", got_a, exp_abc); end
        total++; if (got_b !== exp_abc) begin bad++; $display("FAIL b2b_second_data got=%h exp=%h", got_b, exp_abc); end
        total++; if (fb !== 1'b1 || lb !== 1'b1) begin bad++; $display("FAIL b2b_second_flags got=%b%b exp=11", fb, lb); end
    endtask

    task automatic test_reset_mid();
        load_fill(20, 8'h5A, 1'b0);
        send_msg(1'b0);
        reset = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL midrst_in_ready got=%b exp=0", in_ready); end
        @(negedge clk);
        reset = 1'b0;
        total++; if (blk_valid !== 1'b0) begin bad++; $display("FAIL midrst_blk_valid got=%b exp=0", blk_valid); end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++; if (blk_valid !== 1'b0) begin bad++; $display("FAIL midrst_stray_block cycle=%0d got=%b exp=0", c, blk_valid); end
        end
        load_str("abc");
        run_one();
        total++; if (got_a !== exp_abc) begin bad++; $display("FAIL midrst_abc_data got=%h exp=%h", got_a, exp_abc); end
        total++; if (fa !== 1'b1 || la !== 1'b1) begin bad++; $display("FAIL midrst_abc_flags got=%b%b exp=11", fa, la); end
    endtask

    initial begin
        exp_abc = {8'h61, 8'h62, 8'h63, 8'h80, 416'h0, 64'h18};
        test_reset();
        test_abc();
        test_fpga();
        test_55();
        test_56();
        test_64_65(64);
        test_64_65(65);
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
